if_id_skid_buffer: RTL and testbench
====================================

// Module: if_id_skid_buffer
// PURPOSE
// - Two-entry fetch-to-decode buffer between the PC/instruction-memory fetch stage and decode.
// - Captures {pc, instr} each time a fetch completes and presents them in order to decode.
// - pc_plus2 is recomputed locally so decode does not depend on the PC adder path.
// - Absorbs decode stalls through a valid/ready handshake and drops wrong-path fetches on flush.
// PARAMETERS
// - PC_W     8   PC / address width
// - INSTR_W  16  instruction width (PC advances by 2 per instruction)
// PORTS
// - clk           in   1        system clock; all state updates on the rising edge
// - reset         in   1        synchronous, active-high reset
// - in_valid      in   1        fetch stage presents a valid {in_pc, in_instr}
// - in_ready      out  1        buffer can accept; fetch holds the PC (PC regWrite=0) while low
// - in_pc         in   PC_W     PC of the fetched instruction
// - in_instr      in   INSTR_W  fetched instruction word
// - flush         in   1        branch/jump redirect; discard all buffered and incoming entries
// - out_valid     out  1        head entry valid for decode
// - out_ready     in   1        decode consumes the head entry this cycle
// - out_pc        out  PC_W     head entry PC
// - out_instr     out  INSTR_W  head entry instruction
// - out_pc_plus2  out  PC_W     out_pc + 2, modulo 2^PC_W
// BEHAVIOUR
// - Handshake events:
//   - push = in_valid & in_ready
//   - pop = out_valid & out_ready
// - States track the entry count:
//   - EMPTY (0), ONE (1), FULL (2). FIFO order is preserved.
// - Reset values (while reset is high and on the cycle after):
//   - state EMPTY; out_valid=0; out_pc=0; out_instr=0; out_pc_plus2=2; in_ready=0.
//   - in_ready rises on the first cycle after reset is deasserted.
// - Output timing:
//   - in_ready = (state != FULL), taken from registered state; no combinational path from out_ready.
//   - out_* are driven directly from the head register. Latency is 1 cycle from push to out_valid.
// - State transitions, with flush=0:
//   - EMPTY: push -> ONE.
//   - ONE: push & !pop -> FULL; !push & pop -> EMPTY; push & pop -> ONE, new entry becomes head; neither -> ONE.
//   - FULL: pop -> ONE, second entry moves to head. No push is possible since in_ready=0.
// - Flush has priority over push and pop:
//   - Next state is EMPTY and any same-cycle input is dropped.
//   - out_valid=0 on the following cycle. out_pc/out_instr keep their stale values; they are don't-care while invalid.
//   - A pop in the flush cycle is still a legal consume: decode has taken the head.
// - Output stability:
//   - While out_valid & !out_ready, out_pc/out_instr/out_pc_plus2 stay stable.
//   - Data on in_* is ignored when push=0.
// - Arithmetic:
//   - out_pc_plus2 wraps, e.g. out_pc=8'hFE -> 8'h00.
//   - No other width conversion; the PC is never sign-extended.
// - Reset mid-operation overrides flush, push and pop. Every buffered entry is lost.
// CONFIGURATION
// - IFID_STALL_CNT_EN defined:
//   - Adds output stall_cnt [15:0]: +1 per cycle where out_valid & !out_ready.
//   - Saturates at 16'hFFFF. Cleared only by reset; flush does not clear it.
// - IFID_STALL_CNT_EN undefined:
//   - The stall_cnt port and counter are absent. Behaviour is otherwise identical.
// TESTING
// - Reset: hold reset 2 cycles with in_valid=1 -> out_valid=0, in_ready=0 during reset; in_ready=1 on the first cycle after.
// - Pass-through: out_ready=1, push pc=8'h10/instr=16'hA5A5 -> next cycle out_valid=1, out_pc=8'h10, out_instr=16'hA5A5, out_pc_plus2=8'h12.
// - Backpressure: out_ready=0, push pc 8'h20 then 8'h22 -> in_ready=0, head holds 8'h20; raise out_ready -> 8'h20 then 8'h22 in order, then out_valid=0.
// - Push+pop in ONE: head 8'h30, push 8'h32 with out_ready=1 -> state stays ONE, next head 8'h32, in_ready stays 1.
// - Flush: FULL with 8'h40/8'h42, assert flush with in_valid=1 pc=8'h44 -> next cycle out_valid=0, in_ready=1; 8'h44 is never output.
// - Wrap and stall counter: push pc=8'hFE -> out_pc_plus2=8'h00; with IFID_STALL_CNT_EN, 3 stalled cycles -> stall_cnt=3.

Source files
------------

// File: rtl/if_id_skid_buffer.sv
// Two-entry fetch-to-decode buffer with a valid/ready handshake, flush, and a local pc+2.
// Optional stall counter enabled by defining IFID_STALL_CNT_EN.
module if_id_skid_buffer #(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned INSTR_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc_plus2
`ifdef IFID_STALL_CNT_EN
  ,
  output logic [15:0]        stall_cnt
`endif
);

  localparam int unsigned STATE_W = 2;
  localparam logic [1:0] S_EMPTY = 2'b00;
  localparam logic [1:0] S_ONE   = 2'b01;
  localparam logic [1:0] S_FULL  = 2'b10;

  logic [STATE_W-1:0] state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [PC_W-1:0]    head_pc_q, head_pc_d;
  logic [INSTR_W-1:0] head_instr_q, head_instr_d;
  logic [PC_W-1:0]    head_pc2_q, head_pc2_d;
  logic [PC_W-1:0]    tail_pc_q, tail_pc_d;
  logic [INSTR_W-1:0] tail_instr_q, tail_instr_d;

  logic push_c;
  logic pop_c;

  assign push_c = in_valid & in_ready_q;
  assign pop_c  = out_valid_q & out_ready;

  // Next-state and entry movement; flush empties the buffer but leaves stale data in place.
  always_comb begin
    state_d      = state_q;
    head_pc_d    = head_pc_q;
    head_instr_d = head_instr_q;
    tail_pc_d    = tail_pc_q;
    tail_instr_d = tail_instr_q;

    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (push_c) begin
            head_pc_d    = in_pc;
            head_instr_d = in_instr;
            state_d      = S_ONE;
          end
        end
        S_ONE: begin
          if (push_c && pop_c) begin
            head_pc_d    = in_pc;
            head_instr_d = in_instr;
          end else if (push_c) begin
            tail_pc_d    = in_pc;
            tail_instr_d = in_instr;
            state_d      = S_FULL;
          end else if (pop_c) begin
            state_d = S_EMPTY;
          end
        end
        S_FULL: begin
          if (pop_c) begin
            head_pc_d    = tail_pc_q;
            head_instr_d = tail_instr_q;
            state_d      = S_ONE;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end

    head_pc2_d  = PC_W'(head_pc_d + PC_W'(2));
    in_ready_d  = (state_d != S_FULL);
    out_valid_d = (state_d != S_EMPTY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_EMPTY;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      head_pc_q    <= '0;
      head_instr_q <= '0;
      head_pc2_q   <= PC_W'(2);
      tail_pc_q    <= '0;
      tail_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      head_pc_q    <= head_pc_d;
      head_instr_q <= head_instr_d;
      head_pc2_q   <= head_pc2_d;
      tail_pc_q    <= tail_pc_d;
      tail_instr_q <= tail_instr_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_pc       = head_pc_q;
  assign out_instr    = head_instr_q;
  assign out_pc_plus2 = head_pc2_q;

`ifdef IFID_STALL_CNT_EN
  // Saturating count of cycles where decode holds off a valid head entry.
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_q && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  // No stall counter in this build.
`endif

endmodule

// File: tb/tb_if_id_skid_buffer.sv
// Directed bench for if_id_skid_buffer: reset, pass-through, backpressure, push+pop, flush, wrap.
// Stall counter checks are compiled in when IFID_STALL_CNT_EN is defined.
module tb_if_id_skid_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_pc;
  logic [15:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_pc;
  logic [15:0] out_instr;
  logic [7:0]  out_pc_plus2;
`ifdef IFID_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  if_id_skid_buffer #(.PC_W(8), .INSTR_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_instr     (in_instr),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_instr    (out_instr),
    .out_pc_plus2 (out_pc_plus2)
`ifdef IFID_STALL_CNT_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] pc, input logic [15:0] ins);
    in_valid = v;
    in_pc    = pc;
    in_instr = ins;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b1, 8'h55, 16'h5555);

    // Reset held two cycles with in_valid high
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_out_pc", 32'(out_pc), 32'h0);
    chk("rst_out_instr", 32'(out_instr), 32'h0);
    chk("rst_pc_plus2", 32'(out_pc_plus2), 32'h2);
`ifdef IFID_STALL_CNT_EN
    chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
`endif
    tick();
    chk("rst2_in_ready", 32'(in_ready), 32'h0);
    chk("rst2_out_valid", 32'(out_valid), 32'h0);

    reset = 1'b0;
    drive(1'b0, 8'h00, 16'h0000);
    #1;
    chk("post_rst_in_ready_low", 32'(in_ready), 32'h0);
    tick();
    chk("post_rst_in_ready", 32'(in_ready), 32'h1);
    chk("post_rst_out_valid", 32'(out_valid), 32'h0);

    // Pass-through
    out_ready = 1'b1;
    drive(1'b1, 8'h10, 16'hA5A5);
    tick();
    chk("pt_out_valid", 32'(out_valid), 32'h1);
    chk("pt_out_pc", 32'(out_pc), 32'h10);
    chk("pt_out_instr", 32'(out_instr), 32'hA5A5);
    chk("pt_pc_plus2", 32'(out_pc_plus2), 32'h12);
    chk("pt_in_ready", 32'(in_ready), 32'h1);
    drive(1'b0, 8'h00, 16'h0000);
    tick();
    chk("pt_drain_valid", 32'(out_valid), 32'h0);

    // Backpressure fills to FULL; a third offer is ignored
    out_ready = 1'b0;
    drive(1'b1, 8'h20, 16'h1111);
    tick();
    chk("bp1_out_pc", 32'(out_pc), 32'h20);
    chk("bp1_in_ready", 32'(in_ready), 32'h1);
    drive(1'b1, 8'h22, 16'h2222);
    tick();
    chk("bp2_in_ready", 32'(in_ready), 32'h0);
    chk("bp2_out_pc", 32'(out_pc), 32'h20);
    chk("bp2_out_instr", 32'(out_instr), 32'h1111);
    drive(1'b1, 8'h24, 16'h2424);
    tick();
    chk("bp3_in_ready", 32'(in_ready), 32'h0);
    chk("bp3_out_pc_stable", 32'(out_pc), 32'h20);
    chk("bp3_pc_plus2_stable", 32'(out_pc_plus2), 32'h22);
`ifdef IFID_STALL_CNT_EN
    chk("bp3_stall_cnt", 32'(stall_cnt), 32'h2);
`endif
    drive(1'b0, 8'h00, 16'h0000);
    out_ready = 1'b1;
    tick();
    chk("bp4_out_valid", 32'(out_valid), 32'h1);
    chk("bp4_out_pc", 32'(out_pc), 32'h22);
    chk("bp4_out_instr", 32'(out_instr), 32'h2222);
    chk("bp4_in_ready", 32'(in_ready), 32'h1);
    tick();
    chk("bp5_out_valid", 32'(out_valid), 32'h0);

    // Push and pop in the same cycle while holding one entry
    out_ready = 1'b0;
    drive(1'b1, 8'h30, 16'h3030);
    tick();
    chk("pp1_out_pc", 32'(out_pc), 32'h30);
    out_ready = 1'b1;
    drive(1'b1, 8'h32, 16'h3232);
    tick();
    chk("pp2_out_valid", 32'(out_valid), 32'h1);
    chk("pp2_out_pc", 32'(out_pc), 32'h32);
    chk("pp2_out_instr", 32'(out_instr), 32'h3232);
    chk("pp2_in_ready", 32'(in_ready), 32'h1);
    drive(1'b0, 8'h00, 16'h0000);
    tick();
    chk("pp3_out_valid", 32'(out_valid), 32'h0);

    // Flush from FULL with a same-cycle offer
    out_ready = 1'b0;
    drive(1'b1, 8'h40, 16'h4040);
    tick();
    drive(1'b1, 8'h42, 16'h4242);
    tick();
    chk("fl_full_in_ready", 32'(in_ready), 32'h0);
    flush = 1'b1;
    drive(1'b1, 8'h44, 16'h4444);
    tick();
    chk("fl_out_valid", 32'(out_valid), 32'h0);
    chk("fl_in_ready", 32'(in_ready), 32'h1);
`ifdef IFID_STALL_CNT_EN
    chk("fl_stall_cnt_kept", 32'(stall_cnt), 32'h4);
`endif
    flush = 1'b0;
    drive(1'b0, 8'h00, 16'h0000);
    tick();
    chk("fl_after_out_valid", 32'(out_valid), 32'h0);
    tick();
    chk("fl_after2_out_valid", 32'(out_valid), 32'h0);

    // PC wrap and three stalled cycles
    out_ready = 1'b0;
    drive(1'b1, 8'hFE, 16'hBEEF);
    tick();
    chk("wr_out_pc", 32'(out_pc), 32'hFE);
    chk("wr_pc_plus2", 32'(out_pc_plus2), 32'h00);
    drive(1'b0, 8'h00, 16'h0000);
    tick(); tick(); tick();
    chk("wr_hold_pc", 32'(out_pc), 32'hFE);
    chk("wr_hold_instr", 32'(out_instr), 32'hBEEF);
    chk("wr_hold_valid", 32'(out_valid), 32'h1);
`ifdef IFID_STALL_CNT_EN
    chk("wr_stall_cnt", 32'(stall_cnt), 32'h7);
`endif
    out_ready = 1'b1;
    tick();
    chk("wr_drain_valid", 32'(out_valid), 32'h0);

    // Reset mid-operation overrides an active push
    out_ready = 1'b0;
    drive(1'b1, 8'h60, 16'h6060);
    tick();
    chk("mr_pre_valid", 32'(out_valid), 32'h1);
    reset = 1'b1;
    drive(1'b1, 8'h62, 16'h6262);
    tick();
    chk("mr_out_valid", 32'(out_valid), 32'h0);
    chk("mr_in_ready", 32'(in_ready), 32'h0);
    chk("mr_out_pc", 32'(out_pc), 32'h0);
    chk("mr_pc_plus2", 32'(out_pc_plus2), 32'h2);
`ifdef IFID_STALL_CNT_EN
    chk("mr_stall_cnt", 32'(stall_cnt), 32'h0);
`endif
    reset = 1'b0;
    drive(1'b0, 8'h00, 16'h0000);
    tick();
    chk("mr_after_in_ready", 32'(in_ready), 32'h1);
    chk("mr_after_out_valid", 32'(out_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
